// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer.
//   D_WIDTH         default datapath width
//   SH_*            shift opcodes carried on the op port
//   ST_*            sequencer state encodings
package shift_seq_pkg;

  localparam int D_WIDTH = 32;

  localparam logic [1:0] SH_SLL  = 2'b00;
  localparam logic [1:0] SH_SRL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_PASS = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..MAX_STEP bits.
//   op      shift type (SLL / SRL / SRA / pass-through)
//   amount  bits to shift this step, 0..MAX_STEP
//   data    value to shift
//   result  data shifted once by amount
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int DW       = D_WIDTH,
  parameter int MAX_STEP = 4,
  parameter int KW       = $clog2(MAX_STEP) + 1
) (
  input  logic [1:0]    op,
  input  logic [KW-1:0] amount,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] result
);

  always_comb begin
    result = data;
    case (op)
      SH_SLL:  result = data << amount;
      SH_SRL:  result = data >> amount;
      SH_SRA:  result = $signed(data) >>> amount;
      default: result = data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer for SLL/SRL/SRA. A request is accepted with
// start while idle or done, then shifted MAX_STEP bits (or fewer) per clock.
// Completion is flagged with a one-cycle done pulse and the result on d_out.
//   clk    system clock, rising edge
//   rst    asynchronous active-high reset
//   start  request strobe, honoured in IDLE or DONE only
//   op     shift type: 00 SLL, 01 SRL, 10 SRA, 11 pass-through
//   shamt  shift amount 0..31
//   d_in   operand
//   busy   high while shifting
//   done   one-cycle completion pulse, d_out valid
//   d_out  result register
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int DW       = D_WIDTH,
  parameter int MAX_STEP = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [4:0]    shamt,
  input  logic [DW-1:0] d_in,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] d_out
);

  localparam int KW = $clog2(MAX_STEP) + 1;

  logic [1:0]    state;
  logic [1:0]    op_q;
  logic [4:0]    rem;
  logic [DW-1:0] acc;

  logic [4:0]    shamt_sat;
  logic [KW-1:0] step_k;
  logic [4:0]    rem_next;
  logic [DW-1:0] step_q;
  logic          accept;

  // Narrow datapaths cap the amount at DW so the result is fully shifted out.
  always_comb begin
    shamt_sat = shamt;
    if ((DW < 32) && (int'(shamt) > DW))
      shamt_sat = 5'(DW);
  end

  always_comb begin
    if (int'(rem) > MAX_STEP)
      step_k = KW'(MAX_STEP);
    else
      step_k = KW'(rem);
    rem_next = rem - 5'(step_k);
  end

  shift_step #(
    .DW       (DW),
    .MAX_STEP (MAX_STEP),
    .KW       (KW)
  ) u_step (
    .op     (op_q),
    .amount (step_k),
    .data   (acc),
    .result (step_q)
  );

  assign accept = start && (state != ST_SHIFT);
  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_q  <= SH_SLL;
      rem   <= '0;
      acc   <= '0;
      d_out <= '0;
    end else if (accept) begin
      op_q <= op;
      rem  <= shamt_sat;
      acc  <= d_in;
      if ((shamt_sat == 5'd0) || (op == SH_PASS)) begin
        d_out <= d_in;
        state <= ST_DONE;
      end else begin
        state <= ST_SHIFT;
      end
    end else begin
      case (state)
        ST_SHIFT: begin
          acc <= step_q;
          rem <= rem_next;
          if (rem_next == 5'd0) begin
            d_out <= step_q;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
module tb_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] d_in;
  logic        busy;
  logic        done;
  logic [31:0] d_out;

  int n_vec;
  int n_err;

  shift_seq #(
    .DW       (32),
    .MAX_STEP (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .d_in  (d_in),
    .busy  (busy),
    .done  (done),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge, hold it across one rising edge,
  // then scramble the inputs to show they are only sampled at accept.
  task automatic issue(input logic [1:0] o, input logic [4:0] s, input logic [31:0] d);
    start = 1'b1; op = o; shamt = s; d_in = d;
    @(negedge clk);
    start = 1'b0; op = ~o; shamt = ~s; d_in = 32'hDEADBEEF;
  endtask

  task automatic wait_done(output int busy_n, output logic seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [4:0] s,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_busy);
    int   bn;
    logic seen;
    @(negedge clk);
    issue(o, s, d);
    wait_done(bn, seen);
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bn), 32'(exp_busy));
    check({tag, "_d_out"}, d_out, exp);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse_1cyc"}, 32'(done), 32'd0);
    check({tag, "_d_out_hold"}, d_out, exp);
  endtask

  initial begin
    int   bn;
    int   ndone;
    logic seen;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; op = 2'b00; shamt = 5'd0; d_in = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d_out", d_out, 32'h0);
    rst = 1'b0;

    run_op("sra5",  2'b10, 5'd5,  32'h80000000, 32'hFC000000, 2);
    run_op("sll31", 2'b00, 5'd31, 32'h00000001, 32'h80000000, 8);
    run_op("srl4",  2'b01, 5'd4,  32'hF0000000, 32'h0F000000, 1);
    run_op("pass",  2'b11, 5'd9,  32'h12345678, 32'h12345678, 0);
    run_op("sll0",  2'b00, 5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5, 0);

    // Busy rejection: second start during the SRA run must be ignored.
    @(negedge clk);
    issue(2'b10, 5'd12, 32'hFFFF0000);
    check("rej_busy_at_pulse", 32'(busy), 32'd1);
    start = 1'b1; op = 2'b00; shamt = 5'd1; d_in = 32'h00000001;
    @(negedge clk);
    start = 1'b0;
    wait_done(bn, seen);
    check("rej_done_seen", 32'(seen), 32'd1);
    check("rej_busy_cycles", 32'(bn), 32'd2);
    check("rej_d_out", d_out, 32'hFFFFFFF0);

    // Back-to-back: new request presented during the done cycle.
    issue(2'b01, 5'd1, 32'h80000000);
    check("b2b_no_idle_busy", 32'(busy), 32'd1);
    check("b2b_hold_prev", d_out, 32'hFFFFFFF0);
    @(negedge clk);
    check("b2b_done", 32'(done), 32'd1);
    check("b2b_d_out", d_out, 32'h40000000);

    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rej_no_extra_done", 32'(ndone), 32'd0);

    // Reset in the 3rd busy cycle of an SLL by 20.
    issue(2'b00, 5'd20, 32'h00000001);
    @(negedge clk);
    @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_d_out", d_out, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rstmid_no_done", 32'(ndone), 32'd0);

    run_op("fresh", 2'b00, 5'd20, 32'h00000001, 32'h00100000, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer for the MIPS shift group: SLL, SRL and SRA.
- It sits directly upstream of the ALU writeback mux, in the same slot as the barrel-shift stage.
- It accepts a shift request with a start pulse and splits the 5-bit shift amount into steps of at most MAX_STEP bits per cycle, applying one step per clock.
- It reports completion with a one-cycle done pulse.

Parameters:
- DW, default `D_WIDTH (32): datapath width.
- MAX_STEP, default 4: maximum bits shifted per cycle. Must be a power of 2, with 1 <= MAX_STEP <= 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only when the block can accept (IDLE or DONE).
- op  in  2  shift type: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- shamt  in  5  shift amount, 0..31.
- d_in  in  DW  operand.
- busy  out  1  high while in SHIFT; start is ignored while busy.
- done  out  1  one-cycle pulse; d_out is valid in that cycle.
- d_out  out  DW  result register.

Behaviour:
- Reset and clocking:
  - One clock.
  - Reset is asynchronous and active-high.
  - While rst is high: state=IDLE, busy=0, done=0, d_out=0, internal accumulator=0, remaining count=0.
- States:
  - IDLE: done=0, busy=0.
  - SHIFT: busy=1, done=0.
  - DONE: done=1, busy=0.
- Accept edge E0 (state is IDLE or DONE, start=1):
  - Latch acc=d_in, rem=shamt, op.
  - If shamt==0 or op==11: load d_out=d_in and go to DONE.
  - Otherwise go to SHIFT.
- Each SHIFT edge:
  - k = min(rem, MAX_STEP).
  - acc is shifted by k:
    - SLL fills with zeros from the LSB side.
    - SRL fills with zeros from the MSB side.
    - SRA fills with copies of acc[DW-1].
  - rem -= k.
  - If the new rem is 0: load d_out with the shifted value and go to DONE.
  - Otherwise stay in SHIFT.
- DONE:
  - done=1 for exactly that cycle.
  - Next edge: if start=1, accept a new request (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: done is high in the cycle following edge E0 + ceil(shamt/MAX_STEP).
  - Example with MAX_STEP=4: shamt=0 gives 1 edge, shamt=4 gives 1 shift edge, shamt=31 gives 8 shift edges.
- d_out:
  - Updated only on entry to DONE.
  - Holds its value through IDLE and the next SHIFT, until the next DONE entry.
  - Intermediate acc values are never visible on d_out.
- start while in SHIFT: ignored, with no effect on the operation in flight; the requester must re-assert it later.
- Inputs: op, shamt and d_in are sampled only at the accept edge; changes at any other time have no effect.
- Width: shamt is 5 bits, so at most 31. The case shamt >= DW cannot occur at DW=32; for DW<32, shamt is saturated to DW.
- Reset during SHIFT or DONE: immediate return to IDLE with d_out=0. No done pulse is generated for the aborted operation.

Decomposition:
- define.h (shared): D_WIDTH and the opcodes `SH_SLL=2'b00, `SH_SRL=2'b01, `SH_SRA=2'b10, `SH_PASS=2'b11.
- One natural sub-module: shift_step.
  - Purely combinational.
  - Inputs: op, amount (0..MAX_STEP), data.
  - Output: the data shifted once by that amount.
  - Instantiated once in the SHIFT datapath.
- The FSM, rem counter and d_out register stay in shift_seq.

Test Plan:
- SRA, d_in=0x80000000, shamt=5 -> two busy cycles (shifts of 4 then 1); done pulse with d_out=0xFC000000.
- SLL, d_in=0x00000001, shamt=31 -> 8 busy cycles; done with d_out=0x80000000; busy low in the done cycle.
- SRL, d_in=0xF0000000, shamt=4 -> 1 busy cycle; d_out=0x0F000000. Then op=11, d_in=0x12345678, shamt=9 -> done on the next edge, d_out=0x12345678, busy never asserted.
- Busy rejection: during an SRA 0xFFFF0000 >>12 run, pulse start with SLL 0x1 <<1 -> ignored; done once, d_out=0xFFFFFFF0.
- Back-to-back: start held high in the DONE cycle with SRL 0x80000000 >>1 -> accepted with no IDLE cycle; the next done has d_out=0x40000000.
- Reset mid-op: assert rst during the 3rd busy cycle of an SLL by 20 -> busy=0, done=0, d_out=0 immediately (asynchronous); no done pulse afterwards; a fresh request completes normally.
